calc_frame_ctrl: RTL and testbench
==================================

# calc_frame_ctrl

Byte-level framing controller between the I2C slave and the combinational `calculator` core. Collects an opcode byte and two 32-bit big-endian operands from the I2C write stream, drives the calculator's operand/operation inputs, and captures and width-masks the 64-bit result in one exec cycle. Serves a status byte plus the 8 result bytes back to the I2C slave on reads.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; everything in this block is clocked on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i2c_start` in 1: one-cycle strobe on I2C START/repeated START.
- `rx_data` in 8: byte written by the I2C master.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `tx_pop` in 1: one-cycle strobe; the slave has consumed `tx_data` and wants the next byte.
- `tx_data` out 8: current read byte, combinational from registers.
- `calc_a` out 32: operand A to the calculator, registered.
- `calc_b` out 32: operand B to the calculator, registered.
- `calc_op` out 2: operation to the calculator (00 add, 01 sub, 10 mul, 11 div), registered.
- `calc_result` in 64: calculator output.
- `busy` out 1: high in RX_A, RX_B or EXEC.
- `result_ready` out 1: a result from a complete frame is held.

## Operation
- Frame is 9 bytes: opcode, A[31:24..7:0], B[31:24..7:0].
- Opcode byte: bits[1:0] = op. Bits[7:2] must be 0.
- States:
  - IDLE: waits for an opcode byte.
  - RX_A: 2-bit byte counter, 0..3.
  - RX_B: 2-bit byte counter, 0..3.
  - EXEC: exactly 1 cycle.
  - DONE: holds the result.
- IDLE or DONE, `rx_valid`, valid opcode:
  - latch `calc_op`.
  - clear `result_ready`, `div_zero` and `frame_err`.
  - counter = 0, go to RX_A.
- IDLE or DONE, `rx_valid`, invalid opcode (bits[7:2] ≠ 0): set `frame_err`, go to IDLE, keep everything else.
- RX_A: each byte shifts in as `calc_a <= {calc_a[23:0], rx_data}`. After the 4th byte, counter = 0 and go to RX_B. RX_B works the same way on `calc_b` and goes to EXEC.
- EXEC: capture the masked `calc_result` into `res_reg`, set `result_ready`, go to DONE.
- Width masking at capture:
  - add/sub: `res_reg = {31'b0, calc_result[32:0]}`.
  - mul: `res_reg = calc_result[63:0]`.
  - div: `res_reg = {32'b0, calc_result[31:0]}`.
  - `div_zero` = (op == 11 && `calc_b` == 0).
- Bits outside the masked range are never taken from the calculator. It does not drive all 64 bits for every op.
- `rx_valid` during EXEC: byte dropped, `frame_err` set, and the result is still captured normally.
- `i2c_start`:
  - read index = 0.
  - in RX_A/RX_B: abandon the partial frame, set `frame_err`, go to IDLE.
  - in IDLE/DONE/EXEC: no state change.
- `i2c_start` and `rx_valid` in the same cycle: apply the start first, then treat the byte as an opcode in IDLE.
- Read side: 4-bit index, 0..8.
  - index 0: status = {`result_ready`, `div_zero`, `frame_err`, `busy`, 2'b00, `calc_op`}.
  - index 1..8: `res_reg[63:56]` .. `res_reg[7:0]`.
  - `tx_pop` increments the index; after 8 it wraps to 0.
- `res_reg` is never cleared by a new frame; only EXEC overwrites it. Reads mid-frame return the old result with `result_ready` = 0.

## Timing
- Reset values:
  - state IDLE.
  - `calc_a` = `calc_b` = 0, `calc_op` = 0, `res_reg` = 0.
  - `result_ready` = `div_zero` = `frame_err` = 0, `busy` = 0.
  - read index 0, so `tx_data` = 0x00.
- Reset mid-frame discards everything; there is no partial retention.
- Final B byte at cycle N: EXEC at N+1, `result_ready` and `res_reg` visible at N+2. `busy` falls at N+2.
- `calc_a`, `calc_b` and `calc_op` are stable from N+1 onward. The calculator path is a single-cycle combinational path into `res_reg`.
- `tx_pop` at cycle t: `tx_data` shows the next byte at t+1.
- `tx_pop` and `i2c_start` in the same cycle: the index goes to 0.
- Back-to-back `rx_valid` on consecutive cycles is accepted in RX_A and RX_B. No backpressure exists.

## Test plan
- Add: send 00, 00000005, 00000007; pop 9 bytes.
  - Status reads 0x80, then result bytes 00×7, 0C.
  - `busy` is high from the opcode cycle until N+2.
- Mul: send 02, FFFFFFFF, FFFFFFFF.
  - Status 0x82, result FFFFFFFE00000001.
  - Sub 0−1 (01, 00000000, 00000001) reads status 0x81 and result 00000001FFFFFFFF; the upper 31 bits are zero even if the calculator drives garbage there.
- Div: send 03, 00000064, 00000000.
  - Status 0xC3, result 0.
  - Then send 03, 00000064, 00000007: status 0x83, result 0x0E.
- Abort: send opcode 00 plus 3 bytes of A, then `i2c_start`.
  - Status 0x20 with state IDLE.
  - A following full add frame completes with status 0x80.
  - Opcode 0x04 gives status 0x20 and stays IDLE.
- Read wrap and simultaneity:
  - 10 pops return status, 8 bytes, then status again.
  - `i2c_start` plus `rx_valid`=00 in the same cycle enters RX_A.
  - `rx_valid` during EXEC sets `frame_err` and still yields a correct result.
- Reset mid-frame after 6 bytes: all outputs return to their reset values, and `tx_data` = 0x00.

Source files
------------

// File: rtl/calc_frame_ctrl.sv
// Framing controller between the I2C slave byte stream and the combinational calculator:
// collects opcode + two big-endian operands, captures the width-masked result, serves status/result bytes.
module calc_frame_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_pop,
    output logic [7:0]  tx_data,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic [1:0]  calc_op,
    input  logic [63:0] calc_result,
    output logic        busy,
    output logic        result_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX_A = 3'd1,
        RX_B = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    state_t      byte_state;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] calc_a_q, calc_a_d;
    logic [31:0] calc_b_q, calc_b_d;
    logic [1:0]  calc_op_q, calc_op_d;
    logic [63:0] res_q, res_d;
    logic        result_ready_q, result_ready_d;
    logic        div_zero_q, div_zero_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  rd_idx_q, rd_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            calc_a_q       <= 32'd0;
            calc_b_q       <= 32'd0;
            calc_op_q      <= 2'd0;
            res_q          <= 64'd0;
            result_ready_q <= 1'b0;
            div_zero_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            rd_idx_q       <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            calc_a_q       <= calc_a_d;
            calc_b_q       <= calc_b_d;
            calc_op_q      <= calc_op_d;
            res_q          <= res_d;
            result_ready_q <= result_ready_d;
            div_zero_q     <= div_zero_d;
            frame_err_q    <= frame_err_d;
            rd_idx_q       <= rd_idx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        calc_a_d       = calc_a_q;
        calc_b_d       = calc_b_q;
        calc_op_d      = calc_op_q;
        res_d          = res_q;
        result_ready_d = result_ready_q;
        div_zero_d     = div_zero_q;
        frame_err_d    = frame_err_q;
        rd_idx_d       = rd_idx_q;
        byte_state     = state_q;

        // A START abandons a partial frame; a byte arriving with it is then seen as an opcode.
        if (i2c_start) begin
            rd_idx_d = 4'd0;
            if (state_q == RX_A || state_q == RX_B) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                byte_state  = IDLE;
            end
        end else if (tx_pop) begin
            rd_idx_d = (rd_idx_q >= 4'd8) ? 4'd0 : rd_idx_q + 4'd1;
        end

        if (state_q == EXEC) begin
            state_d        = DONE;
            result_ready_d = 1'b1;
            div_zero_d     = (calc_op_q == 2'b11) && (calc_b_q == 32'd0);
            case (calc_op_q)
                2'b00, 2'b01: res_d = {31'd0, calc_result[32:0]};
                2'b10:        res_d = calc_result;
                default:      res_d = {32'd0, calc_result[31:0]};
            endcase
        end

        if (rx_valid) begin
            case (byte_state)
                IDLE, DONE: begin
                    if (rx_data[7:2] == 6'd0) begin
                        calc_op_d      = rx_data[1:0];
                        result_ready_d = 1'b0;
                        div_zero_d     = 1'b0;
                        frame_err_d    = 1'b0;
                        cnt_d          = 2'd0;
                        state_d        = RX_A;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                RX_A: begin
                    calc_a_d = {calc_a_q[23:0], rx_data};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = RX_B;
                    end
                end
                RX_B: begin
                    calc_b_d = {calc_b_q[23:0], rx_data};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = EXEC;
                    end
                end
                EXEC: frame_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy         = (state_q == RX_A) || (state_q == RX_B) || (state_q == EXEC);
    assign result_ready = result_ready_q;
    assign calc_a       = calc_a_q;
    assign calc_b       = calc_b_q;
    assign calc_op      = calc_op_q;

    always_comb begin
        tx_data = 8'h00;
        case (rd_idx_q)
            4'd0: tx_data = {result_ready_q, div_zero_q, frame_err_q, busy, 2'b00, calc_op_q};
            4'd1: tx_data = res_q[63:56];
            4'd2: tx_data = res_q[55:48];
            4'd3: tx_data = res_q[47:40];
            4'd4: tx_data = res_q[39:32];
            4'd5: tx_data = res_q[31:24];
            4'd6: tx_data = res_q[23:16];
            4'd7: tx_data = res_q[15:8];
            4'd8: tx_data = res_q[7:0];
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_calc_frame_ctrl.sv
// Scoreboard bench for calc_frame_ctrl: directed frames, expected values queued by stimulus,
// compared by a negedge monitor. A behavioural calculator drives junk into unmasked result bits.
module tb_calc_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        i2c_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_pop;
    logic [7:0]  tx_data;
    logic [31:0] calc_a;
    logic [31:0] calc_b;
    logic [1:0]  calc_op;
    logic [63:0] calc_result;
    logic        busy;
    logic        result_ready;

    calc_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i2c_start    (i2c_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_pop       (tx_pop),
        .tx_data      (tx_data),
        .calc_a       (calc_a),
        .calc_b       (calc_b),
        .calc_op      (calc_op),
        .calc_result  (calc_result),
        .busy         (busy),
        .result_ready (result_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Calculator model with garbage above the bits the controller is meant to keep.
    always_comb begin
        case (calc_op)
            2'b00:   calc_result = {31'h2AAA5555, ({1'b0, calc_a} + {1'b0, calc_b})};
            2'b01:   calc_result = {31'h2AAA5555, ({1'b0, calc_a} - {1'b0, calc_b})};
            2'b10:   calc_result = {32'd0, calc_a} * {32'd0, calc_b};
            default: calc_result = (calc_b == 32'd0) ? {32'hDEADBEEF, 32'd0}
                                                     : {32'hDEADBEEF, calc_a / calc_b};
        endcase
    end

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } item_t;

    item_t       sb_q[$];
    item_t       mon_it;
    logic [63:0] mon_obs;
    logic        chk_req;
    int          errors;
    int          checks;

    localparam int SEL_TX = 0, SEL_BUSY = 1, SEL_RR = 2, SEL_A = 3, SEL_B = 4, SEL_OP = 5;

    always @(negedge clk) begin
        if (chk_req && sb_q.size() > 0) begin
            mon_it = sb_q.pop_front();
            case (mon_it.sel)
                SEL_TX:   mon_obs = {56'd0, tx_data};
                SEL_BUSY: mon_obs = {63'd0, busy};
                SEL_RR:   mon_obs = {63'd0, result_ready};
                SEL_A:    mon_obs = {32'd0, calc_a};
                SEL_B:    mon_obs = {32'd0, calc_b};
                default:  mon_obs = {62'd0, calc_op};
            endcase
            checks++;
            if (mon_obs !== mon_it.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %0h expected %0h", mon_it.name, mon_obs, mon_it.exp);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic start);
        rx_data   = b;
        rx_valid  = 1'b1;
        i2c_start = start;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        i2c_start = 1'b0;
    endtask

    task automatic pulseStart();
        i2c_start = 1'b1;
        @(posedge clk); #1;
        i2c_start = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(w[8*i +: 8], 1'b0);
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(op, 1'b0);
        sendWord(a);
        sendWord(b);
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [63:0] exp,
                               input logic pop);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
        chk_req = 1'b1;
        tx_pop  = pop;
        @(posedge clk); #1;
        chk_req = 1'b0;
        tx_pop  = 1'b0;
    endtask

    task automatic readAll(input string tag, input logic [7:0] status, input logic [63:0] res);
        pulseStart();
        checkOutput($sformatf("%s status", tag), SEL_TX, {56'd0, status}, 1'b1);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s byte%0d", tag, i + 1), SEL_TX, {56'd0, res[63 - 8*i -: 8]}, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        chk_req   = 1'b0;
        rst       = 1'b1;
        i2c_start = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_pop    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst tx_data", SEL_TX, 64'h0, 1'b0);
        checkOutput("rst busy", SEL_BUSY, 64'h0, 1'b0);
        checkOutput("rst result_ready", SEL_RR, 64'h0, 1'b0);
        checkOutput("rst calc_a", SEL_A, 64'h0, 1'b0);
        checkOutput("rst calc_b", SEL_B, 64'h0, 1'b0);
        checkOutput("rst calc_op", SEL_OP, 64'h0, 1'b0);

        $display("[TB] add 5+7 with busy timing");
        applyStimulus(8'h00, 1'b0);
        checkOutput("add busy rx", SEL_BUSY, 64'h1, 1'b0);
        sendWord(32'h5);
        sendWord(32'h7);
        checkOutput("add busy exec", SEL_BUSY, 64'h1, 1'b0);
        checkOutput("add busy done", SEL_BUSY, 64'h0, 1'b0);
        checkOutput("add result_ready", SEL_RR, 64'h1, 1'b0);
        readAll("add", 8'h80, 64'hC);
        checkOutput("wrap status", SEL_TX, 64'h80, 1'b0);

        $display("[TB] mul / sub");
        sendFrame(8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("mul calc_a", SEL_A, 64'hFFFFFFFF, 1'b0);
        checkOutput("mul calc_op", SEL_OP, 64'h2, 1'b0);
        readAll("mul", 8'h82, 64'hFFFFFFFE00000001);
        sendFrame(8'h01, 32'h0, 32'h1);
        readAll("sub", 8'h81, 64'h00000001FFFFFFFF);

        $display("[TB] div");
        sendFrame(8'h03, 32'd100, 32'd0);
        readAll("divz", 8'hC3, 64'h0);
        sendFrame(8'h03, 32'd100, 32'd7);
        checkOutput("div calc_b", SEL_B, 64'h7, 1'b0);
        readAll("div", 8'h83, 64'hE);

        $display("[TB] abort and bad opcode");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        pulseStart();
        checkOutput("abort busy", SEL_BUSY, 64'h0, 1'b0);
        readAll("abort", 8'h20, 64'hE);
        applyStimulus(8'h04, 1'b0);
        checkOutput("badop busy", SEL_BUSY, 64'h0, 1'b0);
        readAll("badop", 8'h20, 64'hE);
        sendFrame(8'h00, 32'h5, 32'h7);
        readAll("readd", 8'h80, 64'hC);

        $display("[TB] start with opcode in same cycle");
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("simul busy", SEL_BUSY, 64'h1, 1'b0);
        checkOutput("simul calc_op", SEL_OP, 64'h0, 1'b0);
        sendWord(32'd10);
        sendWord(32'd20);
        readAll("simul", 8'h80, 64'h1E);

        $display("[TB] byte during exec");
        sendFrame(8'h00, 32'd1, 32'd2);
        applyStimulus(8'h55, 1'b0);
        checkOutput("exec busy", SEL_BUSY, 64'h0, 1'b0);
        readAll("execbyte", 8'hA0, 64'h3);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h02, 1'b0);
        sendWord(32'h11223344);
        applyStimulus(8'h55, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mrst tx_data", SEL_TX, 64'h0, 1'b0);
        checkOutput("mrst busy", SEL_BUSY, 64'h0, 1'b0);
        checkOutput("mrst result_ready", SEL_RR, 64'h0, 1'b0);
        checkOutput("mrst calc_a", SEL_A, 64'h0, 1'b0);
        checkOutput("mrst calc_b", SEL_B, 64'h0, 1'b0);
        checkOutput("mrst calc_op", SEL_OP, 64'h0, 1'b0);
        readAll("mrst", 8'h00, 64'h0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
            errors += sb_q.size();
            checks += sb_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
